ysyx_210544_csr_arbiter: RTL and testbench



---
 rtl/ysyx_210544_csr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ysyx_210544_csr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210544_csr_arbiter.sv
// ysyx_210544_csr_arbiter
// Shares the single CSR register-file port between the exception unit (port 0)
// and the execute-stage CSR-instruction unit (port 1). Each grant performs one
// CSR access: strobes in ACCESS, ack plus read data in RESP. Port 0 may hold
// i_p0_lock across a trap sequence so no CSR instruction interleaves with it.
// Build option: define CSR_ARB_RR_EN to alternate the winner on a tie;
// without it port 0 always wins a tie.
module ysyx_210544_csr_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_p0_req,
  input  logic [11:0] i_p0_addr,
  input  logic        i_p0_ren,
  input  logic        i_p0_wen,
  input  logic [63:0] i_p0_wdata,
  input  logic        i_p0_lock,
  input  logic        i_p1_req,
  input  logic [11:0] i_p1_addr,
  input  logic        i_p1_ren,
  input  logic        i_p1_wen,
  input  logic [63:0] i_p1_wdata,
  output logic        o_p0_ack,
  output logic [63:0] o_p0_rdata,
  output logic        o_p1_ack,
  output logic [63:0] o_p1_rdata,
  output logic [11:0] o_csr_addr,
  output logic        o_csr_ren,
  output logic        o_csr_wen,
  output logic [63:0] o_csr_wdata,
  input  logic [63:0] i_csr_rdata
);

  localparam int DATA_W = 64;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_nxt;

  // Grant decision taken in IDLE; sel = 0 for port 0, 1 for port 1.
  logic gnt_vld_p0;
  logic gnt_sel_p0;

  // Port that owns the access currently in ACCESS/RESP.
  logic owner_p1;
  logic owner_nxt;

  logic [ADDR_W-1:0] csr_addr_nxt;
  logic [DATA_W-1:0] csr_wdata_nxt;
  logic              csr_ren_nxt;
  logic              csr_wen_nxt;
  logic              p0_ack_nxt;
  logic              p1_ack_nxt;
  logic [DATA_W-1:0] p0_rdata_nxt;
  logic [DATA_W-1:0] p1_rdata_nxt;
  logic [DATA_W-1:0] access_rdata;

`ifdef CSR_ARB_RR_EN
  // Winner of the most recent grant; starts at port 1 so port 0 takes the first tie.
  logic last_gnt;
  logic last_gnt_nxt;
`endif

  // ---- stage 0: arbitration in IDLE
  // Pick a winner among the requesters; the lock excludes port 1 entirely.
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_sel_p0 = 1'b0;
    if (state_q == IDLE) begin
`ifdef CSR_ARB_RR_EN
      if (i_p0_lock) begin
        gnt_vld_p0 = i_p0_req;
        gnt_sel_p0 = 1'b0;
      end else if (i_p0_req && i_p1_req) begin
        gnt_vld_p0 = 1'b1;
        gnt_sel_p0 = ~last_gnt;
      end else if (i_p0_req) begin
        gnt_vld_p0 = 1'b1;
        gnt_sel_p0 = 1'b0;
      end else if (i_p1_req) begin
        gnt_vld_p0 = 1'b1;
        gnt_sel_p0 = 1'b1;
      end
`else
      if (i_p0_req) begin
        gnt_vld_p0 = 1'b1;
        gnt_sel_p0 = 1'b0;
      end else if (i_p1_req && !i_p0_lock) begin
        gnt_vld_p0 = 1'b1;
        gnt_sel_p0 = 1'b1;
      end
`endif
    end
  end

  // State register; an asynchronous reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: IDLE -> ACCESS on a grant, then RESP, then back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state_q)
      IDLE:    state_nxt = gnt_vld_p0 ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage 1: ACCESS, CSR file answers combinationally on o_csr_addr
  // A read-less access returns zero rather than whatever the CSR file shows.
  assign access_rdata = o_csr_ren ? i_csr_rdata : {DATA_W{1'b0}};

  // Output next-values: load the winner's fields on grant, close the access in ACCESS.
  always_comb begin
    csr_addr_nxt  = o_csr_addr;
    csr_wdata_nxt = o_csr_wdata;
    csr_ren_nxt   = 1'b0;
    csr_wen_nxt   = 1'b0;
    p0_ack_nxt    = 1'b0;
    p1_ack_nxt    = 1'b0;
    p0_rdata_nxt  = o_p0_rdata;
    p1_rdata_nxt  = o_p1_rdata;
    owner_nxt     = owner_p1;
    if (gnt_vld_p0) begin
      owner_nxt = gnt_sel_p0;
      if (gnt_sel_p0) begin
        csr_addr_nxt  = i_p1_addr;
        csr_wdata_nxt = i_p1_wdata;
        csr_ren_nxt   = i_p1_ren;
        csr_wen_nxt   = i_p1_wen;
      end else begin
        csr_addr_nxt  = i_p0_addr;
        csr_wdata_nxt = i_p0_wdata;
        csr_ren_nxt   = i_p0_ren;
        csr_wen_nxt   = i_p0_wen;
      end
    end
    if (state_q == ACCESS) begin
      if (owner_p1) begin
        p1_ack_nxt   = 1'b1;
        p1_rdata_nxt = access_rdata;
      end else begin
        p0_ack_nxt   = 1'b1;
        p0_rdata_nxt = access_rdata;
      end
    end
  end

  // ---- stage 2: RESP, registered ack and read data
  // Every output is a flop so nothing passes combinationally from inputs to outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_p1    <= 1'b0;
      o_csr_addr  <= {ADDR_W{1'b0}};
      o_csr_wdata <= {DATA_W{1'b0}};
      o_csr_ren   <= 1'b0;
      o_csr_wen   <= 1'b0;
      o_p0_ack    <= 1'b0;
      o_p1_ack    <= 1'b0;
      o_p0_rdata  <= {DATA_W{1'b0}};
      o_p1_rdata  <= {DATA_W{1'b0}};
    end else begin
      owner_p1    <= owner_nxt;
      o_csr_addr  <= csr_addr_nxt;
      o_csr_wdata <= csr_wdata_nxt;
      o_csr_ren   <= csr_ren_nxt;
      o_csr_wen   <= csr_wen_nxt;
      o_p0_ack    <= p0_ack_nxt;
      o_p1_ack    <= p1_ack_nxt;
      o_p0_rdata  <= p0_rdata_nxt;
      o_p1_rdata  <= p1_rdata_nxt;
    end
  end

`ifdef CSR_ARB_RR_EN
  assign last_gnt_nxt = gnt_vld_p0 ? gnt_sel_p0 : last_gnt;

  // Remember who won last so a tie goes to the other port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= 1'b1;
    end else begin
      last_gnt <= last_gnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_210544_csr_arbiter.sv
// Testbench for ysyx_210544_csr_arbiter: table of single accesses, hand-written
// multi-cycle sequences (tie, lock, async reset mid-access) and a randomized run,
// all scored against a transaction-level model of the arbiter and CSR file.
module tb_ysyx_210544_csr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req     [2];
  logic [11:0] f_addr  [2];
  logic        f_ren   [2];
  logic        f_wen   [2];
  logic [63:0] f_wdata [2];
  logic        p0_lock;
  logic [63:0] csr_rdata;

  logic        o_p0_ack, o_p1_ack, o_csr_ren, o_csr_wen;
  logic [63:0] o_p0_rdata, o_p1_rdata, o_csr_wdata;
  logic [11:0] o_csr_addr;

  ysyx_210544_csr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_p0_req    (req[0]),
    .i_p0_addr   (f_addr[0]),
    .i_p0_ren    (f_ren[0]),
    .i_p0_wen    (f_wen[0]),
    .i_p0_wdata  (f_wdata[0]),
    .i_p0_lock   (p0_lock),
    .i_p1_req    (req[1]),
    .i_p1_addr   (f_addr[1]),
    .i_p1_ren    (f_ren[1]),
    .i_p1_wen    (f_wen[1]),
    .i_p1_wdata  (f_wdata[1]),
    .o_p0_ack    (o_p0_ack),
    .o_p0_rdata  (o_p0_rdata),
    .o_p1_ack    (o_p1_ack),
    .o_p1_rdata  (o_p1_rdata),
    .o_csr_addr  (o_csr_addr),
    .o_csr_ren   (o_csr_ren),
    .o_csr_wen   (o_csr_wen),
    .o_csr_wdata (o_csr_wdata),
    .i_csr_rdata (csr_rdata)
  );

  // Power-on contents of the CSR file stub.
  function automatic logic [63:0] csr_init(input logic [11:0] a);
    if (a == 12'h300) return 64'h0000_000A_0000_1800;
    if (a == 12'h340) return 64'h5;
    return {40'hC5_A000_0000, 12'h000, a};
  endfunction

  // CSR file stub: combinational read, write committed at the end of the strobe cycle.
  logic [63:0] csr_mem [0:4095];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= csr_init(12'(i));
      mem_init <= 1'b1;
    end else if (o_csr_wen) begin
      csr_mem[o_csr_addr] <= o_csr_wdata;
    end
  end
  assign csr_rdata = csr_mem[o_csr_addr];

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int cyc;
  int free_at;
  int strobe_at;
  int last_w;
  int ack_at   [2];
  int ack_seen [2];
  logic [63:0] pend_rd [2];
  logic [63:0] hold_rd [2];
  logic [11:0] st_addr;
  logic        st_ren, st_wen;
  logic [63:0] st_wdata;
  logic [63:0] mdl_mem [int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] mdl_read(input logic [11:0] a);
    if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
    return csr_init(a);
  endfunction

  task automatic model_reset();
    free_at   = cyc;
    strobe_at = -1;
    last_w    = 1;
    for (int p = 0; p < 2; p++) begin
      ack_at[p]  = -1;
      hold_rd[p] = 64'd0;
    end
  endtask

  task automatic set_req(input int p, input logic [11:0] a, input logic r, input logic w,
                         input logic [63:0] d);
    req[p]     = 1'b1;
    f_addr[p]  = a;
    f_ren[p]   = r;
    f_wen[p]   = w;
    f_wdata[p] = d;
  endtask

  task automatic rand_req(input int p);
    logic [11:0] a;
    a = ($urandom % 2 == 0) ? 12'h340 + 12'($urandom % 4) : 12'h300 + 12'($urandom % 8);
    set_req(p, a, 1'($urandom), 1'($urandom), {$urandom, $urandom});
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_p0_ack"},    64'(o_p0_ack),   64'd0);
    chk({pfx, "_p1_ack"},    64'(o_p1_ack),   64'd0);
    chk({pfx, "_csr_ren"},   64'(o_csr_ren),  64'd0);
    chk({pfx, "_csr_wen"},   64'(o_csr_wen),  64'd0);
    chk({pfx, "_csr_addr"},  64'(o_csr_addr), 64'd0);
    chk({pfx, "_csr_wdata"}, o_csr_wdata,     64'd0);
    chk({pfx, "_p0_rdata"},  o_p0_rdata,      64'd0);
    chk({pfx, "_p1_rdata"},  o_p1_rdata,      64'd0);
  endtask

  // Compare DUT outputs for the current cycle against the model; requester drops req on ack.
  task automatic cycle_begin();
    for (int p = 0; p < 2; p++) if (ack_at[p] == cyc) hold_rd[p] = pend_rd[p];
    chk("p0_ack",   64'(o_p0_ack),  64'(ack_at[0] == cyc));
    chk("p1_ack",   64'(o_p1_ack),  64'(ack_at[1] == cyc));
    chk("p0_rdata", o_p0_rdata,     hold_rd[0]);
    chk("p1_rdata", o_p1_rdata,     hold_rd[1]);
    chk("csr_ren",  64'(o_csr_ren), 64'(strobe_at == cyc && st_ren));
    chk("csr_wen",  64'(o_csr_wen), 64'(strobe_at == cyc && st_wen));
    if (strobe_at == cyc) begin
      chk("csr_addr",  64'(o_csr_addr), 64'(st_addr));
      chk("csr_wdata", o_csr_wdata,     st_wdata);
    end
    for (int p = 0; p < 2; p++) begin
      if (ack_at[p] == cyc) begin
        req[p]      = 1'b0;
        ack_seen[p] = cyc;
      end
    end
  endtask

  // Model arbitration on the inputs driven this cycle, then advance one clock.
  task automatic cycle_end();
    int w;
    logic [63:0] cur;
    w = -1;
    if (cyc >= free_at) begin
`ifdef CSR_ARB_RR_EN
      if (p0_lock) w = req[0] ? 0 : -1;
      else if (req[0] && req[1]) w = 1 - last_w;
      else if (req[0]) w = 0;
      else if (req[1]) w = 1;
`else
      if (req[0]) w = 0;
      else if (req[1] && !p0_lock) w = 1;
`endif
    end
    if (w >= 0) begin
      cur        = mdl_read(f_addr[w]);
      pend_rd[w] = f_ren[w] ? cur : 64'd0;
      if (f_wen[w]) mdl_mem[int'(f_addr[w])] = f_wdata[w];
      ack_at[w]  = cyc + 2;
      strobe_at  = cyc + 1;
      st_addr    = f_addr[w];
      st_ren     = f_ren[w];
      st_wen     = f_wen[w];
      st_wdata   = f_wdata[w];
      free_at    = cyc + 3;
      last_w     = w;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    int          port;
    logic [11:0] addr;
    logic        ren;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int t0, tl, n0, n1;
    bit got;

    tbl[0] = '{1, 12'h300, 1'b1, 1'b0, 64'h0,               64'h0000_000A_0000_1800};
    tbl[1] = '{1, 12'h340, 1'b1, 1'b1, 64'h9,               64'h5};
    tbl[2] = '{1, 12'h340, 1'b1, 1'b0, 64'h0,               64'h9};
    tbl[3] = '{0, 12'h341, 1'b0, 1'b1, 64'h8000_0010,       64'h0};
    tbl[4] = '{0, 12'h341, 1'b1, 1'b0, 64'h0,               64'h8000_0010};
    tbl[5] = '{1, 12'h123, 1'b0, 1'b0, 64'hDEAD,            64'h0};
    tbl[6] = '{0, 12'h305, 1'b1, 1'b0, 64'h0,               64'hC5A0_0000_0000_0305};
    tbl[7] = '{0, 12'h000, 1'b0, 1'b0, 64'h1234,            64'h0};

    rst     = 1'b0;
    p0_lock = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; f_addr[p] = 12'h0; f_ren[p] = 1'b0; f_wen[p] = 1'b0; f_wdata[p] = 64'h0;
      ack_seen[p] = -1;
    end
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    model_reset();

    // ---- table of single accesses on an idle arbiter
    for (int i = 0; i < 8; i++) begin
      int p;
      p = tbl[i].port;
      set_req(p, tbl[i].addr, tbl[i].ren, tbl[i].wen, tbl[i].wdata);
      ack_seen[p] = -1;
      t0 = cyc;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        cycle_begin();
        if (cyc == t0 + 1) begin
          chk("tbl_strobe_ren", 64'(o_csr_ren),  64'(tbl[i].ren));
          chk("tbl_strobe_wen", 64'(o_csr_wen),  64'(tbl[i].wen));
          chk("tbl_strobe_addr", 64'(o_csr_addr), 64'(tbl[i].addr));
        end
        if (ack_seen[p] == cyc) begin
          got = 1'b1;
          chk("tbl_rdata", (p == 1) ? o_p1_rdata : o_p0_rdata, tbl[i].exp_rd);
          chk("tbl_latency", 64'(cyc - t0), 64'd2);
        end
        cycle_end();
      end
      chk("tbl_acked", 64'(got), 64'd1);
    end

    // ---- simultaneous requests; previous grant went to port 0
    set_req(0, 12'h341, 1'b0, 1'b1, 64'h8000_0010);
    set_req(1, 12'h305, 1'b1, 1'b0, 64'h0);
    ack_seen[0] = -1;
    ack_seen[1] = -1;
    t0 = cyc;
    for (int k = 0; k < 12 && (req[0] || req[1]); k++) begin
      cycle_begin();
      if (ack_seen[1] == cyc) chk("tie_p1_rdata", o_p1_rdata, 64'hC5A0_0000_0000_0305);
      cycle_end();
    end
`ifdef CSR_ARB_RR_EN
    chk("tie_p1_lat", 64'(ack_seen[1] - t0), 64'd2);
    chk("tie_p0_lat", 64'(ack_seen[0] - t0), 64'd5);
`else
    chk("tie_p0_lat", 64'(ack_seen[0] - t0), 64'd2);
    chk("tie_p1_lat", 64'(ack_seen[1] - t0), 64'd5);
`endif

    // ---- lock: four port-0 accesses while port 1 keeps requesting
    p0_lock = 1'b1;
    set_req(1, 12'h305, 1'b1, 1'b0, 64'h0);
    ack_seen[0] = -1;
    ack_seen[1] = -1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 40 && n0 < 4; k++) begin
      cycle_begin();
      if (ack_seen[0] == cyc) n0++;
      if (ack_seen[1] == cyc) n1++;
      if (!req[0] && ack_seen[0] != cyc && n0 < 4)
        set_req(0, 12'h342 + 12'(n0), 1'b1, 1'b1, 64'h1000 + 64'(n0));
      cycle_end();
    end
    for (int k = 0; k < 5; k++) begin
      cycle_begin();
      if (ack_seen[1] == cyc) n1++;
      cycle_end();
    end
    chk("lock_p0_acks", 64'(n0), 64'd4);
    chk("lock_p1_acks", 64'(n1), 64'd0);
    cycle_begin();
    tl = cyc;
    p0_lock = 1'b0;
    cycle_end();
    for (int k = 0; k < 8 && req[1]; k++) begin
      cycle_begin();
      cycle_end();
    end
    chk("unlock_p1_lat", 64'(ack_seen[1] - tl), 64'd2);

    // ---- asynchronous reset while port 1 is in ACCESS
    set_req(1, 12'h300, 1'b1, 1'b0, 64'h0);
    cycle_begin();
    cycle_end();
    cycle_begin();
    chk("pre_rst_ren", 64'(o_csr_ren), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_hold_p1_ack", 64'(o_p1_ack),  64'd0);
      chk("rst_hold_ren",    64'(o_csr_ren), 64'd0);
    end
    model_reset();
    rst = 1'b1;
    ack_seen[1] = -1;
    t0 = cyc;
    for (int k = 0; k < 8 && req[1]; k++) begin
      cycle_begin();
      if (ack_seen[1] == cyc) chk("regrant_rdata", o_p1_rdata, 64'h0000_000A_0000_1800);
      cycle_end();
    end
    chk("regrant_lat", 64'(ack_seen[1] - t0), 64'd2);

    // ---- randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      cycle_begin();
      if ($urandom % 8 == 0) p0_lock = ~p0_lock;
      for (int p = 0; p < 2; p++)
        if (!req[p] && ack_seen[p] != cyc && $urandom % 3 == 0) rand_req(p);
      cycle_end();
    end
    p0_lock = 1'b0;
    for (int k = 0; k < 40 && (req[0] || req[1]); k++) begin
      cycle_begin();
      cycle_end();
    end
    chk("drain_done", 64'(!req[0] && !req[1]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
